// File: rtl/myip_pkg.sv
// Shared types and defaults for the myip_v1_0 horizontal Sobel coprocessor.
// No logic; sizes derived here keep top and sub-module consistent.
package myip_pkg;

  typedef enum logic [1:0] {IDLE, READ, COMPUTE, WRITE} state_t;

  localparam int NUM_WORDS_DEF   = 8;
  localparam int PIXEL_WIDTH_DEF = 8;

  // Counter width for a row of n words; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_grad_1d.sv
// Combinational |next - prev| gradient unit, binarised when MYIP_THRESHOLD_EN is defined.
// Zero latency; no flow control, the caller time-multiplexes it one result per cycle.
module sobel_grad_1d
  import myip_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF
`ifdef MYIP_THRESHOLD_EN
  , parameter int THRESHOLD = 64
`endif
) (
  input  logic [PIXEL_WIDTH-1:0] pix_next,
  input  logic [PIXEL_WIDTH-1:0] pix_prev,
  output logic [PIXEL_WIDTH-1:0] grad
);

  logic signed [PIXEL_WIDTH:0] diff;
  logic        [PIXEL_WIDTH-1:0] mag;

  // One extra bit makes the difference signed; its magnitude always fits PIXEL_WIDTH.
  always_comb begin
    diff = $signed({1'b0, pix_next}) - $signed({1'b0, pix_prev});
    mag  = diff[PIXEL_WIDTH] ? PIXEL_WIDTH'(-diff) : diff[PIXEL_WIDTH-1:0];
`ifdef MYIP_THRESHOLD_EN
    grad = (mag >= PIXEL_WIDTH'(THRESHOLD)) ? '1 : '0;
`else
    grad = mag;
`endif
  end

endmodule

// File: rtl/myip_v1_0.sv
// AXI4-Stream 1-D Sobel [-1 0 +1] over a fixed row; MYIP_THRESHOLD_EN binarises results.
// Latency: first output NUMBER_OF_OUTPUT_WORDS+1 cycles after the last input handshake.
// Backpressure: input accepted only in READ; output held stable while M_AXIS_TREADY is low.
module myip_v1_0
  import myip_pkg::*;
#(
  parameter int NUMBER_OF_INPUT_WORDS  = NUM_WORDS_DEF,
  parameter int NUMBER_OF_OUTPUT_WORDS = NUM_WORDS_DEF,
  parameter int PIXEL_WIDTH            = PIXEL_WIDTH_DEF,
  parameter int C_AXIS_TDATA_WIDTH     = 32
`ifdef MYIP_THRESHOLD_EN
  , parameter int THRESHOLD            = 64
`endif
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  output logic                          S_AXIS_TREADY,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                          S_AXIS_TLAST,
  input  logic                          S_AXIS_TVALID,
  output logic                          M_AXIS_TVALID,
  output logic [C_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                          M_AXIS_TLAST,
  input  logic                          M_AXIS_TREADY
);

  localparam int            CW       = cnt_w(NUMBER_OF_INPUT_WORDS);
  localparam logic [CW-1:0] LAST_IN  = CW'(NUMBER_OF_INPUT_WORDS - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(NUMBER_OF_OUTPUT_WORDS - 1);

  state_t                 state, state_nxt;
  logic [CW-1:0]          rd_cnt, cmp_cnt, wr_cnt, wr_nxt;
  logic [CW-1:0]          prev_idx, next_idx;
  logic [PIXEL_WIDTH-1:0] pix [NUMBER_OF_INPUT_WORDS];
  logic [PIXEL_WIDTH-1:0] res [NUMBER_OF_OUTPUT_WORDS];
  logic [PIXEL_WIDTH-1:0] grad;
  logic [PIXEL_WIDTH-1:0] m_dat;
  logic                   m_vld, m_last;
  logic                   s_hs, m_hs;
  logic                   unused_ok;

  assign unused_ok     = ^{S_AXIS_TLAST, S_AXIS_TDATA[C_AXIS_TDATA_WIDTH-1:PIXEL_WIDTH]};
  assign S_AXIS_TREADY = (state == READ);
  assign s_hs          = S_AXIS_TVALID & S_AXIS_TREADY;
  assign m_hs          = m_vld & M_AXIS_TREADY;
  assign M_AXIS_TVALID = m_vld;
  assign M_AXIS_TLAST  = m_last;
  assign M_AXIS_TDATA  = C_AXIS_TDATA_WIDTH'(m_dat);

  // Row edges replicate the border pixel.
  assign prev_idx = (cmp_cnt == '0)      ? '0      : cmp_cnt - CW'(1);
  assign next_idx = (cmp_cnt == LAST_IN) ? LAST_IN : cmp_cnt + CW'(1);
  assign wr_nxt   = wr_cnt + CW'(1);

  sobel_grad_1d #(
    .PIXEL_WIDTH (PIXEL_WIDTH)
`ifdef MYIP_THRESHOLD_EN
    , .THRESHOLD (THRESHOLD)
`endif
  ) u_grad (
    .pix_next (pix[next_idx]),
    .pix_prev (pix[prev_idx]),
    .grad     (grad)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (S_AXIS_TVALID)                state_nxt = READ;
      READ:    if (s_hs && rd_cnt == LAST_IN)    state_nxt = COMPUTE;
      COMPUTE: if (cmp_cnt == LAST_OUT)          state_nxt = WRITE;
      WRITE:   if (m_hs && m_last)               state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  // Output register loads one cycle after entering WRITE, then refills on each accept.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_cnt  <= '0;
      cmp_cnt <= '0;
      wr_cnt  <= '0;
      m_vld   <= 1'b0;
      m_last  <= 1'b0;
      m_dat   <= '0;
    end else begin
      case (state)
        READ:    if (s_hs) rd_cnt <= (rd_cnt == LAST_IN) ? '0 : rd_cnt + CW'(1);
        COMPUTE: cmp_cnt <= (cmp_cnt == LAST_OUT) ? '0 : cmp_cnt + CW'(1);
        WRITE: begin
          if (!m_vld) begin
            m_vld  <= 1'b1;
            m_dat  <= res[wr_cnt];
            m_last <= (wr_cnt == LAST_OUT);
          end else if (M_AXIS_TREADY) begin
            if (m_last) begin
              wr_cnt <= '0;
              m_vld  <= 1'b0;
              m_last <= 1'b0;
              m_dat  <= '0;
            end else begin
              wr_cnt <= wr_nxt;
              m_dat  <= res[wr_nxt];
              m_last <= (wr_nxt == LAST_OUT);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (s_hs)               pix[rd_cnt] <= S_AXIS_TDATA[PIXEL_WIDTH-1:0];
    if (state == COMPUTE)   res[cmp_cnt] <= grad;
  end

endmodule

// File: tb/tb_myip_v1_0.sv
// Randomised and directed stimulus for myip_v1_0 against a row-level gradient model.
module tb_myip_v1_0;

  localparam int N = 8;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        S_AXIS_TREADY;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TVALID;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY;

  int total = 0;
  int bad   = 0;
  int pix_in  [N];
  int exp_out [N];

  myip_v1_0 dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Row-level reference: |p[i+1]-p[i-1]| with replicated borders.
  task automatic model();
    for (int i = 0; i < N; i++) begin
      int l = (i == 0) ? 0 : i - 1;
      int r = (i == N - 1) ? N - 1 : i + 1;
      int g = pix_in[r] - pix_in[l];
      if (g < 0) g = -g;
`ifdef MYIP_THRESHOLD_EN
      g = (g >= 64) ? 255 : 0;
`endif
      exp_out[i] = g;
    end
  endtask

  task automatic send_row(input int count, input bit gaps, input logic [23:0] hi);
    int  i   = 0;
    int  cyc = 0;
    bit  hs;
    S_AXIS_TVALID = 1'b0;
    while (i < count && cyc < 300) begin
      if (!S_AXIS_TVALID) S_AXIS_TVALID = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      S_AXIS_TDATA = {hi, 8'(pix_in[i])};
      hs = S_AXIS_TVALID && S_AXIS_TREADY;
      @(posedge ACLK); #1;
      cyc++;
      if (hs) begin
        i++;
        S_AXIS_TVALID = 1'b0;
      end
    end
    S_AXIS_TVALID = 1'b0;
    if (i < count) check("send_timeout", 32'(i), 32'(count));
  endtask

  task automatic recv_row(input bit toggle);
    int          j   = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [31:0] hold_d  = '0;
    logic        hold_l  = 1'b0;
    while (j < N && cyc < 300) begin
      M_AXIS_TREADY = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        check("stall_vld",  32'(M_AXIS_TVALID), 32'd1);
        check("stall_data", M_AXIS_TDATA, hold_d);
        check("stall_last", 32'(M_AXIS_TLAST), 32'(hold_l));
      end
      stalled = 1'b0;
      if (M_AXIS_TVALID) begin
        check("no_overlap", 32'(S_AXIS_TREADY), 32'd0);
        if (M_AXIS_TREADY) begin
          check("data", M_AXIS_TDATA, 32'(exp_out[j]));
          check("last", 32'(M_AXIS_TLAST), 32'(j == N - 1));
          j++;
        end else begin
          stalled = 1'b1;
          hold_d  = M_AXIS_TDATA;
          hold_l  = M_AXIS_TLAST;
        end
      end
      @(posedge ACLK); #1;
      cyc++;
    end
    M_AXIS_TREADY = 1'b0;
    if (j < N) check("recv_timeout", 32'(j), 32'(N));
    check("post_pkt_vld", 32'(M_AXIS_TVALID), 32'd0);
  endtask

  task automatic run_pkt(input bit gaps, input bit toggle, input logic [23:0] hi);
    int lat = 0;
    model();
    send_row(N, gaps, hi);
    while (!M_AXIS_TVALID && lat < 50) begin
      @(posedge ACLK); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(N + 1));
    recv_row(toggle);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N; i++) pix_in[i] = 10 * (i + 1);
  endtask

  task automatic load_alt();
    for (int i = 0; i < N; i++) pix_in[i] = (i % 2 == 1) ? 255 : 0;
  endtask

  initial begin
    ARESETN       = 1'b0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TLAST  = 1'b0;
    M_AXIS_TREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_s_tready", 32'(S_AXIS_TREADY), 32'd0);
    check("rst_m_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("rst_m_tlast",  32'(M_AXIS_TLAST),  32'd0);
    check("rst_m_tdata",  M_AXIS_TDATA,       32'd0);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    load_ramp();
    run_pkt(1'b0, 1'b0, 24'h0);
    load_alt();
    run_pkt(1'b0, 1'b0, 24'h0);
    for (int i = 0; i < N; i++) pix_in[i] = 8'h7F;
    run_pkt(1'b0, 1'b0, 24'hABCDEF);

    // Back-to-back packets with no idle gap between them.
    load_ramp();
    run_pkt(1'b0, 1'b0, 24'(($urandom)));
    load_alt();
    run_pkt(1'b0, 1'b0, 24'(($urandom)));

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) pix_in[i] = int'($urandom_range(0, 255));
      if (k == 0) pix_in[0] = 0;
      if (k == 0) pix_in[2] = 255;
      run_pkt(1'b1, 1'b1, 24'($urandom));
    end

    // Abort a partial row with reset, then resend the ramp.
    load_ramp();
    send_row(4, 1'b0, 24'h0);
    check("mid_s_tready", 32'(S_AXIS_TREADY), 32'd1);
    #2 ARESETN = 1'b0;
    #1;
    check("arst_s_tready", 32'(S_AXIS_TREADY), 32'd0);
    check("arst_m_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check("idle_s_tready", 32'(S_AXIS_TREADY), 32'd0);
    run_pkt(1'b1, 1'b1, 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/myip_v1_0.md
Name: myip_v1_0

Overview:
AXI4-Stream coprocessor performing a 1-D horizontal Sobel gradient (kernel [-1 0 +1]) over a fixed-length row of 8-bit pixels.
- Accepts one row of NUMBER_OF_INPUT_WORDS pixels on the slave stream.
- Computes one absolute gradient per pixel.
- Returns the results as one packet on the master stream.
- Sits between a DMA MM2S and S2MM channel in the edge-detection datapath.

Parameters:
- NUMBER_OF_INPUT_WORDS, 8, pixels per row/packet (>=2).
- NUMBER_OF_OUTPUT_WORDS, 8, results per packet; must equal NUMBER_OF_INPUT_WORDS.
- PIXEL_WIDTH, 8, significant pixel bits (TDATA[PIXEL_WIDTH-1:0]).
- C_AXIS_TDATA_WIDTH, 32, stream data width.
- THRESHOLD, 64, binarisation threshold (optional feature only).

Ports:
- ACLK  in  1  single clock, all logic on rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXIS_TREADY  out  1  ready to accept an input word.
- S_AXIS_TDATA  in  32  input pixel in bits [7:0]; upper bits ignored.
- S_AXIS_TLAST  in  1  ignored; packet length is fixed.
- S_AXIS_TVALID  in  1  input word valid.
- M_AXIS_TVALID  out  1  output word valid.
- M_AXIS_TDATA  out  32  result, zero-extended from PIXEL_WIDTH.
- M_AXIS_TLAST  out  1  high with the last output word.
- M_AXIS_TREADY  in  1  downstream ready.

Behaviour:
- FSM states: IDLE, READ, COMPUTE, WRITE.
- Reset (async assert, synchronous deassert use):
  - state=IDLE, counters=0.
  - S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0.
- IDLE: when S_AXIS_TVALID=1, go to READ. No data is consumed in IDLE.
- READ:
  - S_AXIS_TREADY=1 (registered by state).
  - On each TVALID&TREADY edge, store TDATA[7:0] into pix[rd_cnt] and increment rd_cnt.
  - After word NUMBER_OF_INPUT_WORDS-1 is stored, clear rd_cnt and go to COMPUTE.
  - TVALID low stalls the count; it does not abort.
- COMPUTE: one result per cycle for NUMBER_OF_OUTPUT_WORDS cycles, then go to WRITE.
  - res[i] = |pix[i+1] - pix[i-1]|.
  - Edges replicate: pix[-1]=pix[0], pix[N]=pix[N-1].
  - Subtraction uses 9-bit signed width; absolute value always fits 8 bits, so no saturation is needed.
- WRITE:
  - M_AXIS_TVALID=1, M_AXIS_TDATA={24'b0,res[wr_cnt]}.
  - M_AXIS_TLAST=1 only when wr_cnt==NUMBER_OF_OUTPUT_WORDS-1.
  - On TVALID&TREADY, increment wr_cnt; after the last word is accepted, clear wr_cnt and go to IDLE.
  - TDATA/TLAST held stable while TREADY=0.
- Latency: first output valid NUMBER_OF_OUTPUT_WORDS+1 cycles after the last input handshake.
- No overlap between packets: S_AXIS_TREADY=0 in COMPUTE and WRITE; a new packet starts only from IDLE.
- ARESETN low in any state immediately returns to IDLE and discards the partial packet.
- Back-to-back packets are supported; each is processed independently.

Optional Feature:
- Macro MYIP_THRESHOLD_EN.
- Defined: each result is binarised before storage: res[i] = (gradient >= THRESHOLD) ? 0xFF : 0x00.
- Undefined: raw gradient magnitude is output.
- Handshake and timing are identical in both cases.

Decomposition:
- Package myip_pkg holds:
  - FSM state enum (IDLE/READ/COMPUTE/WRITE).
  - Default NUMBER_OF_*_WORDS and PIXEL_WIDTH constants.
  - Counter width constant $clog2(NUMBER_OF_INPUT_WORDS).
- One natural sub-module: sobel_grad_1d, a combinational |a-b| unit (plus the optional threshold), instantiated once and time-multiplexed in COMPUTE.

Test Plan:
- Ramp 10,20,30,40,50,60,70,80 -> outputs 10,20,20,20,20,20,20,10; TLAST only on the 8th word.
- Alternating 0,255,0,255,0,255,0,255 -> 255,0,0,0,0,0,0,255.
- Constant 0x7F x8 -> eight 0x00; upper 24 bits of TDATA zero even when input upper bits are 0xABCDEF.
- Two packets back-to-back (ramp then alternating), M_AXIS_TREADY raised only after input completes -> 16 correct words, two TLAST pulses.
- M_AXIS_TREADY toggled 1/0 during WRITE and S_AXIS_TVALID gapped during READ -> no lost or duplicated words; TDATA stable while stalled.
- ARESETN pulsed after 4 input words, then the ramp is resent -> outputs match the ramp case; with MYIP_THRESHOLD_EN and THRESHOLD=15 the ramp yields 0x00,0xFF x6,0x00.
